// File: rtl/audio_frame_buffer.sv
// Ping-pong audio frame buffer: host fills one bank with BUS_W words, the other bank streams samples.
// Requires SPW >= 2. Define AFB_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module audio_frame_buffer #(
    parameter int SAMPLE_W  = 16,
    parameter int BUS_W     = 512,
    parameter int FRAME_LEN = 2048,
    parameter int CHANNELS  = 1,
    localparam int SPW      = BUS_W / SAMPLE_W,
    localparam int WORDS    = FRAME_LEN * CHANNELS / SPW,
    localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic [BUS_W-1:0]    wr_data,
    input  logic                commit,
    output logic                fill_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic [CH_W-1:0]     out_channel,
    output logic                out_last,
    output logic                frame_done,
    output logic                overrun
`ifdef AFB_OVERRUN_CNT_EN
    ,
    output logic [15:0]         overrun_cnt
`endif
);

    localparam int K_W = (SPW > 1) ? $clog2(SPW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t           state_q, state_d;
    logic             fill_bank_q, fill_bank_d;
    logic             pending_q, pending_d;
    logic             use_rd_q, use_rd_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;
    logic [IDX_W-1:0] w_q, w_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CH_W-1:0]  ch_q, ch_d;

    logic [BUS_W-1:0] mem [2**(IDX_W+1)];
    logic [BUS_W-1:0] rd_q, cur_q, out_word;
    logic             rd_en, copy, wr_ok, commit_ok, drop, hs, last_pos;
    logic [IDX_W-1:0] rd_addr;

    assign fill_ready = !pending_q;
    assign wr_ok      = wr_en && !pending_q && ({1'b0, wr_index} < (IDX_W+1)'(WORDS));
    assign commit_ok  = commit && !pending_q;
    assign drop       = (wr_en || commit) && pending_q;
    assign out_valid  = (state_q == STREAM);
    assign hs         = out_valid && out_ready;
    assign last_pos   = (w_q == IDX_W'(WORDS - 1)) && (k_q == K_W'(SPW - 1));

    // The current word lives in rd_q on its first cycle, then in cur_q so rd_q can prefetch.
    always_comb begin
        out_word    = use_rd_q ? rd_q : cur_q;
        out_sample  = out_valid ? out_word[int'(k_q)*SAMPLE_W +: SAMPLE_W] : '0;
        out_channel = out_valid ? ch_q : '0;
        out_last    = out_valid && last_pos;
        frame_done  = frame_done_q;
        overrun     = overrun_q;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        fill_bank_d  = fill_bank_q;
        pending_d    = pending_q;
        use_rd_d     = use_rd_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q || drop;
        w_d          = w_q;
        k_d          = k_q;
        ch_d         = ch_q;
        rd_en        = 1'b0;
        rd_addr      = '0;
        copy         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit_ok) begin
                    fill_bank_d = ~fill_bank_q;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                rd_en    = 1'b1;
                w_d      = '0;
                k_d      = '0;
                ch_d     = '0;
                use_rd_d = 1'b1;
                state_d  = STREAM;
                if (commit_ok) pending_d = 1'b1;
            end
            default: begin
                if (commit_ok) pending_d = 1'b1;
                if (use_rd_q) begin
                    copy     = 1'b1;
                    use_rd_d = 1'b0;
                    if (w_q != IDX_W'(WORDS - 1)) begin
                        rd_en   = 1'b1;
                        rd_addr = w_q + IDX_W'(1);
                    end
                end
                if (hs) begin
                    ch_d = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
                    if (last_pos) begin
                        frame_done_d = 1'b1;
                        w_d          = '0;
                        k_d          = '0;
                        ch_d         = '0;
                        if (pending_q || commit_ok) begin
                            fill_bank_d = ~fill_bank_q;
                            pending_d   = 1'b0;
                            state_d     = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (k_q == K_W'(SPW - 1)) begin
                        k_d      = '0;
                        w_d      = w_q + IDX_W'(1);
                        use_rd_d = 1'b1;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: RAM and its read/word registers carry no reset; out_sample is gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[{fill_bank_q, wr_index}] <= wr_data;
        if (rd_en) rd_q <= mem[{~fill_bank_q, rd_addr}];
        if (copy)  cur_q <= rd_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_bank_q  <= 1'b0;
            pending_q    <= 1'b0;
            use_rd_q     <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            w_q          <= '0;
            k_q          <= '0;
            ch_q         <= '0;
        end else begin
            state_q      <= state_d;
            fill_bank_q  <= fill_bank_d;
            pending_q    <= pending_d;
            use_rd_q     <= use_rd_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            w_q          <= w_d;
            k_q          <= k_d;
            ch_q         <= ch_d;
        end
    end

`ifdef AFB_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt_q, overrun_cnt_d;

    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (drop && overrun_cnt_q != 16'hFFFF) overrun_cnt_d = overrun_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_cnt_q <= '0;
        else        overrun_cnt_q <= overrun_cnt_d;
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

endmodule
